mult_div_ctrl: RTL and testbench
================================

Name: mult_div_ctrl

Overview:
Sequencing controller for the multi-cycle HI/LO arithmetic unit behind the EX stage. It decodes MULT/MULTU/DIV/DIVU from the EX funct field, latches operands, and runs a fixed-latency multiplier or a 32-step restoring divider. It then holds a 64-bit {hi,lo} result with mult_div_done until the pipeline consumes it. EX converts !mult_div_done into its stall request and writes HI/LO from mult_div_result.

Parameters:
MULT_LATENCY, 2, cycles spent in MUL state (>=1) before DONE
DATA_WIDTH, 32, operand width; divider iteration count equals DATA_WIDTH

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
funct  in  6  EX-stage funct field (`FUNCT_MULT/MULTU/DIV/DIVU start an op)
operand_1  in  32  rs value (multiplicand / dividend)
operand_2  in  32  rt value (multiplier / divisor)
flush  in  1  pipeline flush (exception/eret); cancels any op
stall_ex  in  1  hold from a later stage; EX instruction stays in place
mult_div_done  out  1  result valid for the instruction currently in EX
mult_div_result  out  64  {hi[63:32], lo[31:0]}
busy  out  1  state != IDLE (debug/perf)

Behaviour:
- Reset (sync, rst=1): state=IDLE, mult_div_done=0, mult_div_result=0, busy=0, counter=0. Reset dominates flush and start.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE: when funct is one of the four ops and flush=0, latch op kind, signedness, operand_1, operand_2. Next state:
  - MULT/MULTU: MUL, counter=MULT_LATENCY-1.
  - DIV/DIVU with divisor!=0: DIV, counter=31; abs values are loaded for the signed case.
  - Divide by zero: FIX directly.
- Otherwise IDLE holds.
- MUL: product is 64-bit. MULT uses 33-bit sign-extended operands; MULTU uses zero-extended operands. The product is registered in MUL. When counter=0, go to DONE; otherwise decrement.
- DIV: restoring, one quotient bit per cycle, 32 cycles, on unsigned magnitudes. Partial remainder is 33 bits. When counter=0, go to FIX.
- FIX (1 cycle):
  - Signed: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Divide by zero, any signedness: hi=latched operand_1, lo=32'hFFFFFFFF.
  - Then go to DONE.
- DONE: mult_div_done=1 and mult_div_result valid; both are registered outputs. If stall_ex=1, stay in DONE; a new start is not accepted, and funct is ignored. If stall_ex=0, go to IDLE the next cycle with done=0. This guarantees one execution per instruction.
- Latency is counted from the IDLE start cycle (cycle 0) to the first cycle with done=1:
  - MUL: MULT_LATENCY+1 (3 at default).
  - DIV: 34 (1 latch + 32 iterate + 1 fix).
  - Divide by zero: 2.
- mult_div_result holds its last value outside DONE and is only updated on entry to DONE. done is 0 in every state except DONE.
- flush=1 in any state: next state=IDLE, done=0, result unchanged. A start in the same cycle as flush is ignored.
- Operands are latched at start. Later changes on operand_1, operand_2 and funct during MUL/DIV/FIX are ignored.
- Division of 0x80000000 by -1 (signed): quotient=0x80000000, remainder=0. This is natural wrap, with no trap.
- busy=1 in MUL, DIV, FIX and DONE.

Decomposition:
- Funct encodings come from shared funct.v; widths (`DATA_BUS`, `MULT_DIV_BUS`) come from bus.v. Add a state localparam set inside the module; no new package entries are needed beyond `MULT_DIV_BUS` already in bus.v.
- Sub-module: div_iter_core, holding the 33-bit partial remainder/quotient shift register. It has load and step inputs, with quotient/remainder outputs. The FSM, sign handling and MUL path stay in mult_div_ctrl.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at cycle 3, result=0xFFFFFFFE_00000001. One cycle of done with stall_ex=0, then IDLE.
- MULT -3 (0xFFFFFFFD) * 7 -> result=0xFFFFFFFF_FFFFFFEB.
- DIV -7/2 -> done exactly at cycle 34, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU 100/7 -> hi=2, lo=14.
- DIVU 5/0 -> done at cycle 2, hi=5, lo=0xFFFFFFFF.
- DIV 10/3 with flush at cycle 10 -> IDLE at cycle 11, done never asserts, result unchanged. A new MULTU 2*3 completes with result=6.
- MULT 4*5 with stall_ex=1 for 3 cycles in DONE -> done stays 1 for 4 cycles with result=20, no restart. The next MULT is accepted only after returning to IDLE.
- rst asserted mid-DIV -> next cycle done=0, result=0, state IDLE.

Source files
------------

// File: rtl/mult_div_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer:
// EX funct encodings and controller state type.
package mult_div_ctrl_pkg;

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } md_state_e;

    function automatic logic is_md_funct(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/div_iter_core.sv
// Restoring divider datapath: one quotient bit per step on unsigned
// magnitudes; remainder stays below the divisor so W bits hold it.
module div_iter_core #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    logic [W-1:0] rem_q;
    logic [W-1:0] quot_q;
    logic [W-1:0] dsor_q;
    logic [W:0]   shifted;
    logic [W:0]   trial;

    assign shifted = {rem_q, quot_q[W-1]};
    assign trial   = shifted - {1'b0, dsor_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quot_q <= '0;
            dsor_q <= '0;
        end else if (load) begin
            rem_q  <= '0;
            quot_q <= dividend;
            dsor_q <= divisor;
        end else if (step) begin
            // Keep the trial difference only when it did not borrow
            if (!trial[W]) begin
                rem_q  <= trial[W-1:0];
                quot_q <= {quot_q[W-2:0], 1'b1};
            end else begin
                rem_q  <= shifted[W-1:0];
                quot_q <= {quot_q[W-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mult_div_ctrl.sv
// Multi-cycle HI/LO sequencer: decodes MULT/MULTU/DIV/DIVU, runs the
// multiplier or divider, and holds {hi,lo} with done until EX consumes it.
module mult_div_ctrl
    import mult_div_ctrl_pkg::*;
#(
    parameter int MULT_LATENCY = 2,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              funct,
    input  logic [DATA_WIDTH-1:0]   operand_1,
    input  logic [DATA_WIDTH-1:0]   operand_2,
    input  logic                    flush,
    input  logic                    stall_ex,
    output logic                    mult_div_done,
    output logic [2*DATA_WIDTH-1:0] mult_div_result,
    output logic                    busy
);

    localparam int W       = DATA_WIDTH;
    localparam int CNT_MAX = (W > MULT_LATENCY) ? W : MULT_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX);

    md_state_e          state, state_n;
    logic [CNT_W-1:0]   cnt_q;
    logic [W-1:0]       a_q, b_q;
    logic               sgn_q;
    logic               div0_q;
    logic               done_q;
    logic [2*W-1:0]     result_q;

    logic               start;
    logic               op_div;
    logic               op_sgn;
    logic [W-1:0]       a_abs, b_abs;
    logic [W-1:0]       quot, rem;
    logic [W-1:0]       quot_s, rem_s;
    logic [2*W-1:0]     a_ext, b_ext, prod;
    logic [2*W-1:0]     fix_val;

    assign start  = is_md_funct(funct) && !flush;
    assign op_div = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
    assign op_sgn = (funct == FUNCT_DIV) || (funct == FUNCT_MULT);
    assign a_abs  = (op_sgn && operand_1[W-1]) ? -operand_1 : operand_1;
    assign b_abs  = (op_sgn && operand_2[W-1]) ? -operand_2 : operand_2;

    div_iter_core #(.W(W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (state == S_IDLE && start && op_div),
        .step      (state == S_DIV),
        .dividend  (a_abs),
        .divisor   (b_abs),
        .quotient  (quot),
        .remainder (rem)
    );

    // Extending to full product width keeps the multiply modular and exact
    assign a_ext = {{W{sgn_q & a_q[W-1]}}, a_q};
    assign b_ext = {{W{sgn_q & b_q[W-1]}}, b_q};
    assign prod  = a_ext * b_ext;

    assign quot_s  = (sgn_q && (a_q[W-1] ^ b_q[W-1])) ? -quot : quot;
    assign rem_s   = (sgn_q && a_q[W-1]) ? -rem : rem;
    assign fix_val = div0_q ? {a_q, {W{1'b1}}} : {rem_s, quot_s};

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (!op_div)
                        state_n = S_MUL;
                    else if (operand_2 == '0)
                        state_n = S_FIX;
                    else
                        state_n = S_DIV;
                end
            end
            S_MUL:  if (cnt_q == '0) state_n = S_DONE;
            S_DIV:  if (cnt_q == '0) state_n = S_FIX;
            S_FIX:  state_n = S_DONE;
            S_DONE: if (!stall_ex) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (flush)
            state_n = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            div0_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= (state_n == S_DONE);
            if (state == S_IDLE && start) begin
                a_q    <= operand_1;
                b_q    <= operand_2;
                sgn_q  <= op_sgn;
                div0_q <= op_div && (operand_2 == '0);
                cnt_q  <= op_div ? CNT_W'(W - 1) : CNT_W'(MULT_LATENCY - 1);
            end else if ((state == S_MUL || state == S_DIV) && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (state_n == S_DONE && state != S_DONE)
                result_q <= (state == S_MUL) ? prod : fix_val;
        end
    end

    assign mult_div_done   = done_q;
    assign mult_div_result = result_q;
    assign busy            = (state != S_IDLE);

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: directed and random ops
// against an arithmetic reference model, plus flush/stall/reset cases.
module tb_mult_div_ctrl;
    import mult_div_ctrl_pkg::*;

    localparam int ML = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  funct;
    logic [31:0] op1, op2;
    logic        flush, stall_ex;
    logic        done;
    logic [63:0] result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_ctrl #(.MULT_LATENCY(ML), .DATA_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .funct           (funct),
        .operand_1       (op1),
        .operand_2       (op2),
        .flush           (flush),
        .stall_ex        (stall_ex),
        .mult_div_done   (done),
        .mult_div_result (result),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_result(input logic [5:0] f,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb;
        int     ia, ib;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        if (f == FUNCT_MULT)  return 64'(sa * sb);
        if (f == FUNCT_MULTU) return ua * ub;
        if (b == 32'h0)       return {a, 32'hFFFF_FFFF};
        if (f == FUNCT_DIVU)  return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {32'h0, 32'h8000_0000};
        ia = a;
        ib = b;
        return {32'(ia % ib), 32'(ia / ib)};
    endfunction

    function automatic int ref_latency(input logic [5:0] f, input logic [31:0] b);
        if (f == FUNCT_MULT || f == FUNCT_MULTU) return ML + 1;
        if (b == 32'h0) return 2;
        return 34;
    endfunction

    task automatic start_op(input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b);
        @(negedge clk);
        funct = f;
        op1   = a;
        op2   = b;
        @(posedge clk);
        #1;
        funct = 6'h00;
        op1   = $urandom;
        op2   = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, output int lat,
                          output logic [63:0] res, output logic idle_after);
        start_op(f, a, b);
        wait_done(lat);
        res = result;
        @(negedge clk);
        idle_after = (done === 1'b0) && (busy === 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; funct = 6'h00; op1 = '0; op2 = '0;
        flush = 1'b0; stall_ex = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++;
        if (result !== 64'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_mult();
        logic [5:0]  f;
        logic [31:0] a, b;
        logic [63:0] res, exp;
        int          lat;
        logic        idle;
        for (int i = 0; i < 17; i++) begin
            if (i == 0) begin f = FUNCT_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
            else if (i == 1) begin f = FUNCT_MULT; a = 32'hFFFF_FFFD; b = 32'd7; end
            else begin
                f = ($urandom_range(0, 1) == 1) ? FUNCT_MULT : FUNCT_MULTU;
                a = $urandom;
                b = $urandom;
            end
            exp = ref_result(f, a, b);
            run_op(f, a, b, lat, res, idle);
            n_checks++;
            if (lat !== ref_latency(f, b)) begin
                n_fail++;
                $display("FAIL mul_latency[%0d] got %0d want %0d", i, lat, ref_latency(f, b));
            end
            n_checks++;
            if (res !== exp) begin
                n_fail++;
                $display("FAIL mul_result[%0d] %h*%h got %h want %h", i, a, b, res, exp);
            end
            n_checks++;
            if (!idle) begin n_fail++; $display("FAIL mul_idle[%0d] done=%b busy=%b want 0 0", i, done, busy); end
        end
    endtask

    task automatic test_div();
        logic [5:0]  f;
        logic [31:0] a, b;
        logic [63:0] res, exp;
        int          lat;
        logic        idle;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) begin f = FUNCT_DIV; a = 32'hFFFF_FFF9; b = 32'd2; end
            else if (i == 1) begin f = FUNCT_DIVU; a = 32'd100; b = 32'd7; end
            else if (i == 2) begin f = FUNCT_DIVU; a = 32'd5; b = 32'd0; end
            else if (i == 3) begin f = FUNCT_DIV; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (i == 4) begin f = FUNCT_DIV; a = 32'hFFFF_FFF0; b = 32'd0; end
            else begin
                f = ($urandom_range(0, 1) == 1) ? FUNCT_DIV : FUNCT_DIVU;
                a = $urandom;
                case ($urandom_range(0, 3))
                    0: b = 32'h0;
                    1: b = $urandom_range(1, 20);
                    2: b = -$urandom_range(1, 20);
                    default: b = $urandom;
                endcase
            end
            exp = ref_result(f, a, b);
            run_op(f, a, b, lat, res, idle);
            n_checks++;
            if (lat !== ref_latency(f, b)) begin
                n_fail++;
                $display("FAIL div_latency[%0d] got %0d want %0d", i, lat, ref_latency(f, b));
            end
            n_checks++;
            if (res !== exp) begin
                n_fail++;
                $display("FAIL div_result[%0d] %h/%h got %h want %h", i, a, b, res, exp);
            end
            n_checks++;
            if (!idle) begin n_fail++; $display("FAIL div_idle[%0d] done=%b busy=%b want 0 0", i, done, busy); end
        end
    endtask

    task automatic test_flush();
        logic [63:0] prev, res;
        logic        seen, idle;
        int          lat;
        prev = result;
        seen = 1'b0;
        start_op(FUNCT_DIV, 32'd10, 32'd3);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle busy=%b done=%b want 0 0", busy, done);
        end
        n_checks++;
        if (result !== prev) begin n_fail++; $display("FAIL flush_result got %h want %h", result, prev); end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_done saw done=1 want never"); end
        run_op(FUNCT_MULTU, 32'd2, 32'd3, lat, res, idle);
        n_checks++;
        if (res !== 64'd6 || lat !== 3) begin
            n_fail++;
            $display("FAIL flush_recover got %h lat %0d want 6 lat 3", res, lat);
        end
    endtask

    task automatic test_stall();
        int lat;
        stall_ex = 1'b1;
        start_op(FUNCT_MULT, 32'd4, 32'd5);
        wait_done(lat);
        n_checks++;
        if (lat !== 3 || result !== 64'd20) begin
            n_fail++;
            $display("FAIL stall_first got %h lat %0d want 20 lat 3", result, lat);
        end
        funct = FUNCT_MULT;
        op1   = 32'd6;
        op2   = 32'd7;
        for (int k = 4; k <= 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b1 || result !== 64'd20) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] done=%b res=%h want 1 20", k, done, result);
            end
        end
        stall_ex = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release done=%b busy=%b want 0 0", done, busy);
        end
        @(posedge clk);
        #1 funct = 6'h00;
        wait_done(lat);
        n_checks++;
        if (lat !== 3 || result !== 64'd42) begin
            n_fail++;
            $display("FAIL stall_next got %h lat %0d want 42 lat 3", result, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        logic [31:0] a, b;
        int          lat;
        logic        idle;
        start_op(FUNCT_DIV, 32'hDEAD_BEEF, 32'd13);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || result !== 64'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid done=%b res=%h busy=%b want 0 0 0", done, result, busy);
        end
        a = $urandom_range(1, 1000);
        b = $urandom_range(1, 1000);
        run_op(FUNCT_MULTU, a, b, lat, res, idle);
        n_checks++;
        if (res !== ref_result(FUNCT_MULTU, a, b)) begin
            n_fail++;
            $display("FAIL reset_recover got %h want %h", res, ref_result(FUNCT_MULTU, a, b));
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_flush();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
